// File: rtl/jmp_unit.sv
`default_nettype none
// ============================================================================
// Module   : jmp_unit
// Brief    : Next-PC target unit with base register and return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module jmp_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jmp_en,
    input  logic [1:0]       jmp_mode,
    input  logic [WIDTH-1:0] jmp_offset,
    input  logic             base_reg_ld,
    input  logic [WIDTH-1:0] base_reg_data,
    input  logic [WIDTH-1:0] pc_next,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] out_addr,
    output logic             jmp_taken,
    output logic [CW-1:0]    stack_cnt,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             ovf,
    output logic             unf
);

    localparam int          IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  c_MODE_ABS = 2'b00;
    localparam logic [1:0]  c_MODE_REL = 2'b01;
    localparam logic [1:0]  c_MODE_RET = 2'b10;
    localparam logic [1:0]  c_MODE_CAL = 2'b11;
    localparam logic [CW-1:0] c_FULL   = CW'(DEPTH);

    logic [WIDTH-1:0] r_base;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] r_ras [DEPTH];

    logic             w_full;
    logic             w_empty;
    logic             w_call;
    logic             w_ret;
    logic             w_push;
    logic             w_pop;
    logic [IW-1:0]    w_wr_idx;
    logic [IW-1:0]    w_top_idx;
    logic [WIDTH-1:0] w_top;

    assign w_full    = (r_cnt == c_FULL);
    assign w_empty   = (r_cnt == '0);
    assign w_call    = jmp_en && (jmp_mode == c_MODE_CAL);
    assign w_ret     = jmp_en && (jmp_mode == c_MODE_RET);
    assign w_push    = w_call && !w_full;
    assign w_pop     = w_ret && !w_empty;
    // Push slot is only used when not full, so r_cnt < DEPTH fits in IW bits.
    assign w_wr_idx  = IW'(r_cnt);
    assign w_top_idx = IW'(r_cnt - CW'(1));
    assign w_top     = r_ras[w_top_idx];

    always_comb begin
        out_addr = pc_next;
        if (jmp_en) begin
            case (jmp_mode)
                c_MODE_ABS: out_addr = jmp_offset;
                c_MODE_REL: out_addr = r_base + jmp_offset;
                c_MODE_RET: out_addr = w_empty ? pc_next : (w_top + jmp_offset);
                c_MODE_CAL: out_addr = jmp_offset;
                default:    out_addr = pc_next;
            endcase
        end
    end

    assign jmp_taken   = jmp_en;
    assign stack_cnt   = r_cnt;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign ovf         = r_ovf;
    assign unf         = r_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            if (base_reg_ld) begin
                r_base <= base_reg_data;
            end
            if (w_push) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (w_pop) begin
                r_cnt <= r_cnt - CW'(1);
            end
            // A new error in the same cycle as a clear leaves the flag set.
            if (w_call && w_full) begin
                r_ovf <= 1'b1;
            end else if (flag_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_ret && w_empty) begin
                r_unf <= 1'b1;
            end else if (flag_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    // Stack storage needs no reset; occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_ras[w_wr_idx] <= pc_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jmp_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_jmp_unit
// Brief    : Directed self-checking bench for jmp_unit (WIDTH=8, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jmp_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             jmp_en;
    logic [1:0]       jmp_mode;
    logic [WIDTH-1:0] jmp_offset;
    logic             base_reg_ld;
    logic [WIDTH-1:0] base_reg_data;
    logic [WIDTH-1:0] pc_next;
    logic             flag_clr;
    logic [WIDTH-1:0] out_addr;
    logic             jmp_taken;
    logic [CW-1:0]    stack_cnt;
    logic             stack_full;
    logic             stack_empty;
    logic             ovf;
    logic             unf;

    int n_tests = 0;
    int n_fail  = 0;

    jmp_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .jmp_en       (jmp_en),
        .jmp_mode     (jmp_mode),
        .jmp_offset   (jmp_offset),
        .base_reg_ld  (base_reg_ld),
        .base_reg_data(base_reg_data),
        .pc_next      (pc_next),
        .flag_clr     (flag_clr),
        .out_addr     (out_addr),
        .jmp_taken    (jmp_taken),
        .stack_cnt    (stack_cnt),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .ovf          (ovf),
        .unf          (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] mode,
                         input logic [7:0] off, input logic [7:0] pc);
        jmp_en     = en;
        jmp_mode   = mode;
        jmp_offset = off;
        pc_next    = pc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int cnt, input logic full,
                               input logic empty, input logic o, input logic u);
        check_eq({tag, "_cnt"},   32'(stack_cnt),   32'(cnt));
        check_eq({tag, "_full"},  32'(stack_full),  32'(full));
        check_eq({tag, "_empty"}, 32'(stack_empty), 32'(empty));
        check_eq({tag, "_ovf"},   32'(ovf),         32'(o));
        check_eq({tag, "_unf"},   32'(unf),         32'(u));
    endtask

    initial begin
        rst = 1'b1; jmp_en = 1'b0; jmp_mode = 2'b00; jmp_offset = '0;
        base_reg_ld = 1'b0; base_reg_data = '0; pc_next = '0; flag_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset then idle
        drive(1'b0, 2'b00, 8'h00, 8'h05);
        check_eq("idle_addr", 32'(out_addr), 32'h05);
        check_eq("idle_taken", 32'(jmp_taken), 32'h0);
        check_state("reset", 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Absolute jump
        drive(1'b1, 2'b00, 8'h9A, 8'h06);
        check_eq("abs_addr", 32'(out_addr), 32'h9A);
        check_eq("abs_taken", 32'(jmp_taken), 32'h1);
        tick();

        // Base-relative: same-cycle load is not bypassed, then wrap
        base_reg_ld = 1'b1; base_reg_data = 8'hF0;
        drive(1'b1, 2'b01, 8'h20, 8'h07);
        check_eq("rel_nobypass", 32'(out_addr), 32'h20);
        tick();
        base_reg_ld = 1'b0;
        drive(1'b1, 2'b01, 8'h20, 8'h08);
        check_eq("rel_wrap", 32'(out_addr), 32'h10);
        tick();

        // CALL / RET pair
        drive(1'b1, 2'b11, 8'h40, 8'h11);
        check_eq("call_addr", 32'(out_addr), 32'h40);
        tick();
        check_state("after_call", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 8'h00, 8'h41);
        check_eq("ret_addr", 32'(out_addr), 32'h11);
        tick();
        check_state("after_ret", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 8'h40, 8'h11);
        tick();
        drive(1'b1, 2'b10, 8'h02, 8'h41);
        check_eq("ret_off2", 32'(out_addr), 32'h13);
        tick();

        // Overflow: five CALLs with pc_next 1..5
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 2'b11, 8'(8'h80 + i), 8'(i));
            check_eq($sformatf("ovf_call%0d_addr", i), 32'(out_addr), 32'(8'h80 + i));
            tick();
            if (i == 4) check_state("full4", 4, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check_state("ovf5", 4, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b10, 8'h00, 8'hEE);
            check_eq($sformatf("pop%0d_addr", i), 32'(out_addr), 32'(4 - i));
            tick();
        end
        check_state("drained", 0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Underflow and flag clearing
        drive(1'b1, 2'b10, 8'h05, 8'h22);
        check_eq("unf_addr", 32'(out_addr), 32'h22);
        tick();
        check_state("unf", 0, 1'b0, 1'b1, 1'b1, 1'b1);
        flag_clr = 1'b1;
        drive(1'b0, 2'b00, 8'h00, 8'h23);
        tick();
        check_state("clr", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 8'h00, 8'h24);
        tick();
        flag_clr = 1'b0;
        check_state("clr_set_wins", 0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset mid-operation with a simultaneous CALL
        drive(1'b1, 2'b11, 8'h50, 8'h31);
        tick();
        drive(1'b1, 2'b11, 8'h50, 8'h32);
        tick();
        check_state("pre_rst", 2, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        drive(1'b1, 2'b11, 8'h50, 8'h33);
        tick();
        rst = 1'b0;
        check_state("mid_rst", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 2'b01, 8'h07, 8'h40);
        check_eq("rst_base", 32'(out_addr), 32'h07);
        drive(1'b1, 2'b10, 8'h00, 8'h41);
        check_eq("rst_ret_empty", 32'(out_addr), 32'h41);
        drive(1'b0, 2'b00, 8'h00, 8'h42);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
